// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the RAM port arbiter: FSM state encoding,
//   requester identifiers, RAM size codes and read/write codes, plus the
//   size-normalising helper applied to data-port requests.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } arbState_t;

   typedef enum logic {
      REQ_F = 1'b0,
      REQ_D = 1'b1
   } reqId_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // The reserved size code is issued to the RAM as a plain word access.
   function automatic logic [1:0] effSize(input logic [1:0] size);
      logic [1:0] result;
      case (size)
         SZ_BYTE: result = SZ_BYTE;
         SZ_HALF: result = SZ_HALF;
         default: result = SZ_WORD;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ram_arb_timeout.sv
// ram_arb_timeout
//   Down-counter guarding the MFC wait. Reloaded while 'load' is high,
//   counts while 'en' is high, and raises 'expired' during the CYCLES-th
//   enabled cycle after a reload.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      reload the counter (arbiter idle)
//   en        count this cycle (arbiter waiting on MFC)
//   expired   combinational: wait limit reached in this cycle
module ram_arb_timeout #(
   parameter int unsigned CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(CYCLES - 1);
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one MFA/MFC RAM port between instruction fetch (F) and
//   load/store data access (D). One transaction runs at a time:
//   IDLE -> ACTIVE -> DONE -> IDLE. Ties are resolved round-robin, the
//   pointer moving to the loser after every grant (first tie goes to F).
// Ports:
//   Clk, reset                         clock, async active-high reset
//   fReq/fAddr -> fGnt/fDone/fRdata    fetch port (word reads only)
//   dReq/dRW/dSize/dAddr/dWdata
//              -> dGnt/dDone/dRdata    load/store port
//   ramMFA/ramRW/ramDataSize/ramAddress/ramDataOut  registered RAM drive
//   ramDataIn/ramMFC                   RAM response
//   memTimeout                         sticky MFC-timeout flag
// Configuration:
//   RAM_ARB_TIMEOUT_EN  when defined, an MFC wait longer than
//                       TIMEOUT_CYCLES aborts the access with read data
//                       32'hDEAD_BEEF and sets memTimeout; otherwise the
//                       arbiter waits indefinitely and memTimeout is 0.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              fReq,
   input  logic [ADDR_W-1:0] fAddr,
   output logic              fGnt,
   output logic              fDone,
   output logic [DATA_W-1:0] fRdata,
   input  logic              dReq,
   input  logic              dRW,
   input  logic [1:0]        dSize,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic              dGnt,
   output logic              dDone,
   output logic [DATA_W-1:0] dRdata,
   output logic              ramMFA,
   output logic              ramRW,
   output logic [1:0]        ramDataSize,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [DATA_W-1:0] ramDataOut,
   input  logic [DATA_W-1:0] ramDataIn,
   input  logic              ramMFC,
   output logic              memTimeout
);

   if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
      $error("ram_port_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arbState_t        state;
   reqId_t           rrPtr;
   reqId_t           owner;
   logic             pickF;
   logic             finishNow;
   logic [DATA_W-1:0] finishData;

   // F wins when it is the only requester or when the tie pointer favours it.
   assign pickF = fReq && (!dReq || (rrPtr == REQ_F));

`ifdef RAM_ARB_TIMEOUT_EN
   logic tmoExpired;

   ram_arb_timeout #(
      .CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk    (Clk),
      .rst    (reset),
      .load   (state == ST_IDLE),
      .en     (state == ST_ACTIVE),
      .expired(tmoExpired)
   );

   // A real MFC on the expiry cycle takes precedence over the timeout.
   always_comb begin
      finishNow  = ramMFC || tmoExpired;
      finishData = ramMFC ? ramDataIn : DATA_W'(32'hDEAD_BEEF);
   end
`else
   always_comb begin
      finishNow  = ramMFC;
      finishData = ramDataIn;
   end

   assign memTimeout = 1'b0;
`endif

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         rrPtr       <= REQ_F;
         owner       <= REQ_F;
         fGnt        <= 1'b0;
         dGnt        <= 1'b0;
         fDone       <= 1'b0;
         dDone       <= 1'b0;
         fRdata      <= '0;
         dRdata      <= '0;
         ramMFA      <= 1'b0;
         ramRW       <= 1'b0;
         ramDataSize <= '0;
         ramAddress  <= '0;
         ramDataOut  <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
         memTimeout  <= 1'b0;
`endif
      end else begin
         fDone <= 1'b0;
         dDone <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fReq || dReq) begin
                  ramMFA <= 1'b1;
                  state  <= ST_ACTIVE;
                  if (pickF) begin
                     owner       <= REQ_F;
                     rrPtr       <= REQ_D;
                     fGnt        <= 1'b1;
                     ramRW       <= RW_READ;
                     ramDataSize <= SZ_WORD;
                     ramAddress  <= fAddr;
                     ramDataOut  <= '0;
                  end else begin
                     owner       <= REQ_D;
                     rrPtr       <= REQ_F;
                     dGnt        <= 1'b1;
                     ramRW       <= dRW;
                     ramDataSize <= effSize(dSize);
                     ramAddress  <= dAddr;
                     ramDataOut  <= (dRW == RW_WRITE) ? dWdata : '0;
                  end
               end
            end
            ST_ACTIVE: begin
               if (finishNow) begin
                  ramMFA <= 1'b0;
                  fGnt   <= 1'b0;
                  dGnt   <= 1'b0;
                  state  <= ST_DONE;
                  if (owner == REQ_F) begin
                     fRdata <= finishData;
                     fDone  <= 1'b1;
                  end else begin
                     if (ramRW == RW_READ) begin
                        dRdata <= finishData;
                     end
                     dDone <= 1'b1;
                  end
`ifdef RAM_ARB_TIMEOUT_EN
                  if (!ramMFC) begin
                     memTimeout <= 1'b1;
                  end
`endif
               end
            end
            ST_DONE: begin
               // Dead cycle: gives the RAM time to drop MFC.
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TMO    = 64;

   logic              Clk = 1'b0;
   logic              reset = 1'b0;
   logic              fReq, fGnt, fDone;
   logic [ADDR_W-1:0] fAddr;
   logic [DATA_W-1:0] fRdata;
   logic              dReq, dRW, dGnt, dDone;
   logic [1:0]        dSize;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] dWdata, dRdata;
   logic              ramMFA, ramRW, ramMFC, memTimeout;
   logic [1:0]        ramDataSize;
   logic [ADDR_W-1:0] ramAddress;
   logic [DATA_W-1:0] ramDataOut, ramDataIn;

   always #5 Clk = ~Clk;

   ram_port_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clk(Clk), .reset(reset),
      .fReq(fReq), .fAddr(fAddr), .fGnt(fGnt), .fDone(fDone), .fRdata(fRdata),
      .dReq(dReq), .dRW(dRW), .dSize(dSize), .dAddr(dAddr), .dWdata(dWdata),
      .dGnt(dGnt), .dDone(dDone), .dRdata(dRdata),
      .ramMFA(ramMFA), .ramRW(ramRW), .ramDataSize(ramDataSize),
      .ramAddress(ramAddress), .ramDataOut(ramDataOut),
      .ramDataIn(ramDataIn), .ramMFC(ramMFC), .memTimeout(memTimeout)
   );

   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic [8:0]  addr;
      logic [31:0] wdata;
   } dReq_t;

   int checks = 0;
   int failures = 0;

   // Stimulus state
   logic [8:0]  fQ[$];
   dReq_t       dQ[$];
   logic [31:0] ramDataQ[$];
   bit fOut, dOut, autoF, autoD, dropEn, noMfc;
   int probF, probD, fixedLat, ramCnt;

   // Reference model: who owns the port, what it must be driving, and
   // which results are visible after the next clock edge.
   int          mOwner;    // 0 none, 1 F, 2 D
   int          mLastWin;  // requester granted most recently
   int          mActCnt;
   bit          mDead, mFDone, mDDone, mTmo;
   logic        mRW;
   logic [1:0]  mSize;
   logic [8:0]  mAddr;
   logic [31:0] mDout, mFR, mDR;

   // Observations for the directed checks
   int          grantLog[$];
   bit          prevF, prevD, prevMfa;
   logic        capRW;
   logic [1:0]  capSize;
   logic [8:0]  capAddr;
   logic [31:0] capDout;
   int          fDoneCnt, dDoneCnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelInit();
      mOwner = 0; mLastWin = 2; mActCnt = 0;
      mDead = 0; mFDone = 0; mDDone = 0; mTmo = 0;
      mRW = 0; mSize = '0; mAddr = '0; mDout = '0; mFR = '0; mDR = '0;
   endtask

   // Advance the model across one clock edge using the inputs now driven.
   task automatic modelStep();
      bit fin;
      logic [31:0] data;
      int win;
      mFDone = 0;
      mDDone = 0;
      if (mOwner == 0) begin
         if (mDead) begin
            mDead = 0;
         end else if (fReq || dReq) begin
            if (fReq && dReq) win = (mLastWin == 1) ? 2 : 1;
            else win = fReq ? 1 : 2;
            mLastWin = win;
            mOwner = win;
            mActCnt = 0;
            if (win == 1) begin
               mRW = 1'b1; mSize = 2'b10; mAddr = fAddr; mDout = '0;
            end else begin
               mRW = dRW;
               mSize = (dSize == 2'b11) ? 2'b10 : dSize;
               mAddr = dAddr;
               mDout = dRW ? 32'h0 : dWdata;
            end
         end
      end else begin
         mActCnt++;
         fin = 0;
         data = ramDataIn;
         if (ramMFC) fin = 1;
`ifdef RAM_ARB_TIMEOUT_EN
         else if (mActCnt == TMO) begin
            fin = 1;
            data = 32'hDEAD_BEEF;
            mTmo = 1;
         end
`endif
         if (fin) begin
            if (mOwner == 1) begin
               mFDone = 1;
               mFR = data;
            end else begin
               mDDone = 1;
               if (mRW) mDR = data;
            end
            mOwner = 0;
            mDead = 1;
         end
      end
   endtask

   task automatic compareAll();
      chk("fGnt", 32'(fGnt), 32'(mOwner == 1));
      chk("dGnt", 32'(dGnt), 32'(mOwner == 2));
      chk("gntOverlap", 32'(fGnt && dGnt), 32'h0);
      chk("ramMFA", 32'(ramMFA), 32'(mOwner != 0));
      chk("fDone", 32'(fDone), 32'(mFDone));
      chk("dDone", 32'(dDone), 32'(mDDone));
      chk("fRdata", fRdata, mFR);
      chk("dRdata", dRdata, mDR);
      chk("memTimeout", 32'(memTimeout), 32'(mTmo));
      if (mOwner != 0) begin
         chk("ramRW", 32'(ramRW), 32'(mRW));
         chk("ramDataSize", 32'(ramDataSize), 32'(mSize));
         chk("ramAddress", 32'(ramAddress), 32'(mAddr));
         chk("ramDataOut", ramDataOut, mDout);
      end
      if (fGnt && !prevF) grantLog.push_back(1);
      if (dGnt && !prevD) grantLog.push_back(2);
      if (ramMFA && !prevMfa) begin
         capRW = ramRW; capSize = ramDataSize; capAddr = ramAddress; capDout = ramDataOut;
      end
      prevF = fGnt; prevD = dGnt; prevMfa = ramMFA;
      if (fDone) fDoneCnt++;
      if (dDone) dDoneCnt++;
   endtask

   task automatic addD(input logic rw, input logic [1:0] size, input logic [8:0] addr,
                       input logic [31:0] wdata);
      dReq_t r;
      r.rw = rw; r.size = size; r.addr = addr; r.wdata = wdata;
      dQ.push_back(r);
   endtask

   task automatic ramResponder();
      if (!ramMFA) begin
         ramMFC = 1'b0;
         ramCnt = 0;
         ramDataIn = $urandom;
      end else if (!ramMFC && !noMfc) begin
         if (ramCnt == 0) ramCnt = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
         ramCnt--;
         if (ramCnt == 0) begin
            ramMFC = 1'b1;
            ramDataIn = (ramDataQ.size() != 0) ? ramDataQ.pop_front() : $urandom;
         end else begin
            ramDataIn = $urandom;
         end
      end else if (!ramMFC) begin
         ramDataIn = $urandom;
      end
   endtask

   task automatic requesters();
      dReq_t r;
      if (fOut && fDone) begin fOut = 0; fReq = 1'b0; end
      if (fOut && fGnt && fReq && dropEn && $urandom_range(0, 9) == 0) fReq = 1'b0;
      if (!fOut) begin
         if (autoF && fQ.size() == 0 && $urandom_range(0, 99) < probF) fQ.push_back(9'($urandom));
         if (fQ.size() != 0) begin
            fAddr = fQ.pop_front(); fReq = 1'b1; fOut = 1;
         end else begin
            fReq = 1'b0; fAddr = 9'($urandom);
         end
      end
      if (dOut && dDone) begin dOut = 0; dReq = 1'b0; end
      if (dOut && dGnt && dReq && dropEn && $urandom_range(0, 9) == 0) dReq = 1'b0;
      if (!dOut) begin
         if (autoD && dQ.size() == 0 && $urandom_range(0, 99) < probD)
            addD(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom), $urandom);
         if (dQ.size() != 0) begin
            r = dQ.pop_front();
            dRW = r.rw; dSize = r.size; dAddr = r.addr; dWdata = r.wdata;
            dReq = 1'b1; dOut = 1;
         end else begin
            dReq = 1'b0; dRW = 1'($urandom); dSize = 2'($urandom);
            dAddr = 9'($urandom); dWdata = $urandom;
         end
      end
   endtask

   task automatic stepCycle();
      ramResponder();
      requesters();
      modelStep();
      @(negedge Clk);
      compareAll();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // which: 1 = next fDone, 2 = next dDone, 3 = ramMFA high
   task automatic runUntil(input int which, input int limit, input string name);
      int f0, d0;
      bit hit;
      f0 = fDoneCnt; d0 = dDoneCnt; hit = 0;
      for (int i = 0; i < limit && !hit; i++) begin
         stepCycle();
         hit = (which == 1) ? (fDoneCnt != f0) : (which == 2) ? (dDoneCnt != d0) : ramMFA;
      end
      chk(name, 32'(hit), 32'h1);
   endtask

   // Entered at a falling edge; reset is raised mid-cycle and the outputs
   // must clear without waiting for a clock edge.
   task automatic doReset();
      #2 reset = 1'b1;
      #1;
      chk("rstMFA", 32'(ramMFA), 32'h0);
      chk("rstGnt", 32'({fGnt, dGnt}), 32'h0);
      chk("rstDone", 32'({fDone, dDone}), 32'h0);
      chk("rstFRdata", fRdata, 32'h0);
      chk("rstDRdata", dRdata, 32'h0);
      chk("rstAddr", 32'(ramAddress), 32'h0);
      chk("rstTmo", 32'(memTimeout), 32'h0);
      fReq = 0; dReq = 0; fAddr = '0; dRW = 0; dSize = '0; dAddr = '0; dWdata = '0;
      ramMFC = 0; ramDataIn = '0; ramCnt = 0;
      fOut = 0; dOut = 0;
      fQ.delete(); dQ.delete(); ramDataQ.delete(); grantLog.delete();
      prevF = 0; prevD = 0; prevMfa = 0; fDoneCnt = 0; dDoneCnt = 0;
      modelInit();
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b0;
      compareAll();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int f0;
      fReq = 0; dReq = 0; fAddr = '0; dRW = 0; dSize = '0; dAddr = '0; dWdata = '0;
      ramMFC = 0; ramDataIn = '0;
      autoF = 0; autoD = 0; dropEn = 0; noMfc = 0; probF = 0; probD = 0; fixedLat = 0;
      @(negedge Clk);
      doReset();

      // Fetch of 9'h010 answered after three cycles
      fixedLat = 3;
      ramDataQ.push_back(32'h2002_0001);
      fQ.push_back(9'h010);
      runUntil(1, 20, "t1_wait");
      chk("t1_rw", 32'(capRW), 32'h1);
      chk("t1_size", 32'(capSize), 32'h2);
      chk("t1_addr", 32'(capAddr), 32'h010);
      chk("t1_fRdata", fRdata, 32'h2002_0001);
      chk("t1_doneCnt", 32'(fDoneCnt), 32'h1);
      run(3);

      // Byte store: write data reaches the RAM, load data stays untouched
      addD(1'b0, 2'b00, 9'h1F0, 32'h0000_00AB);
      runUntil(2, 20, "t2_wait");
      chk("t2_rw", 32'(capRW), 32'h0);
      chk("t2_size", 32'(capSize), 32'h0);
      chk("t2_addr", 32'(capAddr), 32'h1F0);
      chk("t2_dout", capDout, 32'h0000_00AB);
      chk("t2_dRdata", dRdata, 32'h0);
      chk("t2_fRdata", fRdata, 32'h2002_0001);
      run(3);

      // Both requesters held from reset: grants alternate starting with F
      doReset();
      autoF = 1; autoD = 1; probF = 100; probD = 100; fixedLat = 2;
      run(40);
      autoF = 0; autoD = 0;
      chk("t3_grants", 32'(grantLog.size() >= 4), 32'h1);
      for (int i = 0; i < 4; i++) chk("t3_order", 32'(grantLog[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      run(20);

      // Fetch request withdrawn after grant still completes
      fixedLat = 4;
      f0 = fDoneCnt;
      fQ.push_back(9'h123);
      runUntil(3, 10, "t5_grant");
      fReq = 1'b0;
      runUntil(1, 20, "t5_wait");
      chk("t5_doneCnt", 32'(fDoneCnt - f0), 32'h1);
      run(3);

      // Reset while a load is waiting on MFC, then a clean recovery
      noMfc = 1;
      addD(1'b1, 2'b11, 9'h0F0, 32'h0);
      runUntil(3, 10, "t4_wait");
      doReset();
      noMfc = 0;
      fQ.push_back(9'h055);
      runUntil(1, 20, "t4_recover");
      chk("t4_addr", 32'(capAddr), 32'h055);
      run(3);

      // MFC never arrives
      noMfc = 1;
      fQ.push_back(9'h0AA);
      run(TMO + 10);
`ifdef RAM_ARB_TIMEOUT_EN
      chk("t6_tmo", 32'(memTimeout), 32'h1);
      chk("t6_fRdata", fRdata, 32'hDEAD_BEEF);
      chk("t6_mfa", 32'(ramMFA), 32'h0);
`else
      chk("t6_tmo", 32'(memTimeout), 32'h0);
      chk("t6_mfa", 32'(ramMFA), 32'h1);
`endif
      noMfc = 0;
      doReset();

      // Random traffic: both ports, random latency, sizes and withdrawals
      autoF = 1; autoD = 1; probF = 30; probD = 30; dropEn = 1; fixedLat = 0;
      run(3000);
      autoF = 0; autoD = 0;
      run(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
